// File: rtl/ltc5548_sys_pio_out.sv
// ============================================================================
//  Module   : ltc5548_sys_pio_out
//  Purpose  : Avalon-MM output PIO with atomic set/clear and an optional
//             hardware one-shot (enabled by LTC5548_PIO_OUT_PULSE_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ltc5548_sys_pio_out #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam logic [2:0] c_ADDR_DATA  = 3'd0;
  localparam logic [2:0] c_ADDR_LEN   = 3'd2;
  localparam logic [2:0] c_ADDR_PULSE = 3'd3;
  localparam logic [2:0] c_ADDR_SET   = 3'd4;
  localparam logic [2:0] c_ADDR_CLR   = 3'd5;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] w_pulse_mask;
  logic             w_busy;
  logic             unused_wd;

  assign w_wr      = chipselect & ~write_n;
  assign w_wd      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata[31:WIDTH];

  // --------------------------------------------------------------------------
  // Data register with atomic set / clear
  // --------------------------------------------------------------------------
  always_comb begin
    data_d = data_q;
    if (w_wr) begin
      case (address)
        c_ADDR_DATA: data_d = w_wd;
        c_ADDR_SET:  data_d = data_q | w_wd;
        c_ADDR_CLR:  data_d = data_q & ~w_wd;
        default:     data_d = data_q;
      endcase
    end
  end

`ifdef LTC5548_PIO_OUT_PULSE_EN
  // --------------------------------------------------------------------------
  // One-shot: inverts masked pins for exactly len_q cycles, no retrigger
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PULSE_W-1:0] len_q, len_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mask_q, mask_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (w_wr && (address == c_ADDR_LEN)) begin
      len_d = writedata[PULSE_W-1:0];
    end
    case (state_q)
      S_IDLE: begin
        if (w_wr && (address == c_ADDR_PULSE) && (w_wd != '0) && (len_q != '0)) begin
          state_d = S_ACTIVE;
          mask_d  = w_wd;
          cnt_d   = len_q;
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_q - PULSE_W'(1);
        // Mask was raised on the entry edge, so clearing at cnt==1 gives len cycles
        if (cnt_q == PULSE_W'(1)) begin
          mask_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  assign w_pulse_mask = mask_q;
  assign w_busy       = (state_q == S_ACTIVE);

  always_comb begin
    rdata_d = '0;
    case (address)
      c_ADDR_DATA:  rdata_d[WIDTH-1:0] = data_q;
      c_ADDR_LEN:   rdata_d[PULSE_W-1:0] = len_q;
      c_ADDR_PULSE: begin
        rdata_d[31]        = w_busy;
        rdata_d[WIDTH-1:0] = mask_q;
      end
      default:      rdata_d = '0;
    endcase
  end
`else
  localparam int unused_pulse_w = PULSE_W;

  assign w_pulse_mask = '0;
  assign w_busy       = 1'b0;

  always_comb begin
    rdata_d = '0;
    if (address == c_ADDR_DATA) begin
      rdata_d[WIDTH-1:0] = data_q;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registered data, pins and read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      out_q   <= RESET_VALUE;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      out_q   <= data_q ^ w_pulse_mask;
      rdata_q <= rdata_d;
    end
  end

  assign out_port = out_q;
  assign readdata = rdata_q;
  assign busy     = w_busy;

endmodule

`default_nettype wire

// File: doc/ltc5548_sys_pio_out.md
# ltc5548_sys_pio_out

Avalon-MM slave output port for the ltc5548 system: the output-direction counterpart of the system's edge-capturing input PIO. It drives `WIDTH` general-purpose output pins (detector enables, attenuator strobes) from a data register with atomic bit-set/bit-clear access. It also provides an optional hardware one-shot that inverts selected pins for a programmed number of clocks, for strobes too short to time from software.

## Interface
- `WIDTH`, 8: number of output pins, 1..31.
- `RESET_VALUE`, 0: value of `data_reg` and `out_port` after reset.
- `PULSE_W`, 16: width of the pulse-length register and down-counter, 1..31.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  3  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write is `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  WIDTH  registered pin outputs.
- `busy`  out  1  one-shot active.

## Operation
- Register map; unlisted addresses read 0 and ignore writes.
  - Addr 0, DATA (R/W): write loads `data_reg <= writedata[WIDTH-1:0]`.
  - Addr 2, PULSE_LEN (R/W): `PULSE_W` bits, length in clk cycles.
  - Addr 3, PULSE (W: trigger mask). Read returns `{busy, 0…, pulse_mask}`, with `busy` in bit 31.
  - Addr 4, OUTSET (W): `data_reg <= data_reg | wd`.
  - Addr 5, OUTCLEAR (W): `data_reg <= data_reg & ~wd`.
- Every cycle: `out_port <= data_reg ^ pulse_mask`. The output is registered so pins never glitch.
- `readdata` is updated every cycle from the address mux, regardless of `chipselect`. DATA reads return `data_reg`, not `out_port`.
- One-shot FSM has two states:
  - IDLE → ACTIVE on a write to addr 3 with `wd[WIDTH-1:0] != 0` and `pulse_len != 0`. On entry, load `pulse_mask <= wd[WIDTH-1:0]` and `cnt <= pulse_len`.
  - In ACTIVE, `cnt` decrements each cycle. When `cnt == 1`, the FSM clears `pulse_mask` and returns to IDLE. The mask is therefore nonzero for exactly `pulse_len` cycles.
  - Trigger with mask 0 or `pulse_len == 0`: ignored, stays IDLE.
  - Trigger while ACTIVE: ignored, with no retrigger or extension.
- PULSE_LEN written during ACTIVE: stored, but the running pulse is unaffected; the new value applies to the next trigger.
- DATA, OUTSET or OUTCLEAR written during ACTIVE: takes effect normally. Pulsed bits show the inverse of the new `data_reg`.
- `busy = (state == ACTIVE)`.

## Timing
- Reset: `data_reg = RESET_VALUE`, `out_port = RESET_VALUE`, `readdata = 0`, `pulse_len = 0`, `pulse_mask = 0`, `cnt = 0`, FSM IDLE, `busy = 0`.
- Reset asserted mid-pulse aborts the pulse immediately. Pins return to `RESET_VALUE` asynchronously.
- Write sampled at edge E updates `data_reg` at E and `out_port` at E+1.
- Read latency is 1 clock: address at edge E appears on `readdata` after E.
- Pulse trigger sampled at edge E:
  - `busy` and `pulse_mask` rise at E and fall at E+`pulse_len`.
  - Pins invert from E+1 to E+1+`pulse_len`, i.e. `pulse_len` cycles.
- Back-to-back writes are accepted every cycle; there are no wait states.

## Configuration
- `LTC5548_PIO_OUT_PULSE_EN` defined: the one-shot FSM, PULSE_LEN, PULSE and `busy` are implemented as above.
- Not defined: addresses 2 and 3 read 0 and ignore writes. `busy` is tied 0 and `pulse_mask` is constant 0, so `out_port <= data_reg`. No counter logic is synthesized.

## Test plan
- Reset with `RESET_VALUE=8'hA5`, then release → `out_port=8'hA5`, `readdata=0`, `busy=0`. Reading addr 0 returns `0xA5` one cycle later.
- DATA=`0x0F`, OUTSET `0x30`, OUTCLEAR `0x03` on consecutive cycles → `out_port` steps `0x0F`, `0x3F`, `0x3C`, each one cycle after its write.
- PULSE_LEN=5, DATA=`0x00`, PULSE `0x81` → `out_port=0x81` for exactly 5 cycles, then `0x00`. `busy` is high 5 cycles; a read of addr 3 mid-pulse returns `0x80000081`.
- During a 5-cycle pulse: PULSE `0x02` (retrigger) and PULSE_LEN=2 → both ignored for the running pulse. A later trigger of `0x02` lasts 2 cycles.
- Mid-pulse DATA=`0xFF` with mask `0x01` → `out_port=0xFE` until pulse end, then `0xFF`. Asserting `reset_n` mid-pulse → `out_port=RESET_VALUE`, `busy=0` at once.
- Build without `LTC5548_PIO_OUT_PULSE_EN` → write PULSE `0xFF` leaves `out_port` unchanged. Reads of addr 2 and 3 return 0, and `busy` stays 0.
